// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-request record.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;
  // Wide enough for the largest supported requester count (8).
  localparam int MAX_IDW  = 3;

  typedef struct packed {
    logic [REG_AW-1:0]  addr;
    logic [MAX_IDW-1:0] id;
  } rd_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller masks the grant when it cannot accept.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int             cand;
  logic [IDW-1:0] ci;
  logic           found;

  // Scan ptr+1, ptr+2, ... (wrapping) and take the first active request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    ci    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      ci   = IDW'(cand);
      if (!found && req[ci]) begin
        gnt[ci] = 1'b1;
        idx     = ci;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read port among NREQ requesters, round-robin; optional write bypass under RF_BYPASS_EN.
// Latency: accept at edge N, rf_sel driven in cycle N+1, rsp_valid from edge N+1.
// Backpressure: rsp_* held until rsp_ready; req_ready drops once both stages are full and rsp_ready=0.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_AW-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [REG_AW-1:0]      rf_sel,
  input  logic [WIDTH-1:0]       rf_rdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data
`ifdef RF_BYPASS_EN
  ,
  input  logic                   wr_en,
  input  logic [REG_AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data
`endif
);

  logic              a_vld;
  rd_req_t           a_req;
  logic              b_vld;
  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic [REG_AW-1:0] gnt_addr;
  logic              b_adv;
  logic              a_adv;
  logic              xfer;
  logic [WIDTH-1:0]  cap_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // The grant never looks at read data, so there is no path from rf_rdata to req_ready.
  assign b_adv     = !b_vld || rsp_ready;
  assign a_adv     = !a_vld || b_adv;
  assign req_ready = (reset_n && a_adv) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign gnt_addr  = req_addr[gnt_idx*REG_AW +: REG_AW];

  assign rf_sel    = a_req.addr;
  assign rsp_valid = b_vld;

  // Pick the value B captures: XZR reads zero, a same-cycle write wins over the mux.
  always_comb begin
    cap_data = rf_rdata;
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr == a_req.addr)) begin
      cap_data = wr_data;
    end
`endif
    if (a_req.addr == ZERO_REG) begin
      cap_data = '0;
    end
  end

  // Stage A: latch the winning address/ID and move the round-robin pointer on each transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld  <= 1'b0;
      a_req  <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else if (a_adv) begin
      a_vld <= xfer;
      if (xfer) begin
        a_req.addr <= gnt_addr;
        a_req.id   <= MAX_IDW'(gnt_idx);
        rr_ptr     <= gnt_idx;
      end
    end
  end

  // Stage B: capture read data one cycle after accept and hold it until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_vld    <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (b_adv) begin
      b_vld <= a_vld;
      if (a_vld) begin
        rsp_data <= cap_data;
        rsp_id   <= IDW'(a_req.id);
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter (NREQ=4, WIDTH=64).
// Scenario tasks compare DUT outputs against constants and a queue-based model.
// The bypass scenario is built only when RF_BYPASS_EN is defined.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  rf_sel;
  logic [63:0] rf_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [63:0] rsp_data;
`ifdef RF_BYPASS_EN
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
`endif

  logic [4:0]  a [4];
  logic [63:0] mem [32];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: round-robin pointer, items in flight, expected responses.
  int          m_ptr;
  int          m_cnt;
  int          q_id[$];
  logic [63:0] q_data[$];
  int          q_acc[$];

  always #5 clk = ~clk;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign rf_rdata = mem[rf_sel];

  regfile_read_arbiter #(
    .NREQ  (4),
    .WIDTH (64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_rdata  (rf_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef RF_BYPASS_EN
    ,
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`endif
  );

  function automatic int rr_winner(input logic [3:0] v, input int p);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (p + k) % 4;
      if (((v >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rd_model(input logic [4:0] ad);
    return (ad == 5'd31) ? 64'd0 : mem[ad];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 4'd0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    m_ptr = 3;
    m_cnt = 0;
    q_id.delete();
    q_data.delete();
    q_acc.delete();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) a[i] = 5'($urandom_range(0, 30));
    repeat (3) tick();
    @(negedge clk);
    checks++; if (req_ready !== 4'd0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rf_sel !== 5'd0) begin failures++; $display("FAIL reset_rf_sel got=%0d exp=0", rf_sel); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'd0;
  endtask

  task automatic test_single_read();
    apply_reset();
    mem[5]    = 64'h5555;
    a[0]      = 5'd5;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'd0;
    @(negedge clk);
    checks++; if (rf_sel !== 5'd5) begin failures++; $display("FAIL single_rf_sel got=%0d exp=5", rf_sel); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== 64'h5555) begin failures++; $display("FAIL single_rsp_data got=%h exp=5555", rsp_data); end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_no_dup got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [1:0] rid;
    apply_reset();
    for (int i = 0; i < 4; i++) a[i] = 5'(i * 4 + 2);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      eg = 4'd1 << (c % 4);
      checks++; if (req_ready !== eg) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, eg); end
      if (c >= 2) begin
        rid = 2'((c - 2) % 4);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_bubble cyc=%0d got=%b exp=1", c, rsp_valid); end
        checks++; if (rsp_id !== rid) begin failures++; $display("FAIL rr_rsp_id cyc=%0d got=%0d exp=%0d", c, rsp_id, rid); end
        checks++; if (rsp_data !== rd_model(a[rid])) begin failures++; $display("FAIL rr_rsp_data cyc=%0d got=%h exp=%h", c, rsp_data, rd_model(a[rid])); end
      end
      tick();
    end
    req_valid = 4'd0;
  endtask

  task automatic test_backpressure();
    int er [10] = '{1, 2, 4, 0, 0, 0, 8, 1, 2, 4};
    int ei [10] = '{-1, -1, 0, 1, 1, 1, 1, 2, 3, 0};
    int rr [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic [1:0] rid;
    apply_reset();
    for (int i = 0; i < 4; i++) a[i] = 5'(i + 10);
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      rsp_ready = (rr[c] != 0);
      @(negedge clk);
      checks++; if (req_ready !== 4'(er[c])) begin failures++; $display("FAIL bp_grant cyc=%0d got=%b exp=%b", c, req_ready, 4'(er[c])); end
      if (ei[c] >= 0) begin
        rid = 2'(ei[c]);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid cyc=%0d got=%b exp=1", c, rsp_valid); end
        checks++; if (rsp_id !== rid) begin failures++; $display("FAIL bp_rsp_id cyc=%0d got=%0d exp=%0d", c, rsp_id, rid); end
        checks++; if (rsp_data !== rd_model(a[rid])) begin failures++; $display("FAIL bp_rsp_data cyc=%0d got=%h exp=%h", c, rsp_data, rd_model(a[rid])); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_rsp_idle cyc=%0d got=%b exp=0", c, rsp_valid); end
      end
      if (c >= 3 && c <= 5) begin
        checks++; if (rf_sel !== a[2]) begin failures++; $display("FAIL bp_rf_sel_hold cyc=%0d got=%0d exp=%0d", c, rf_sel, a[2]); end
      end
      tick();
    end
    req_valid = 4'd0;
  endtask

  task automatic test_xzr();
    apply_reset();
    mem[31]   = '1;
    a[1]      = 5'd31;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL xzr_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'd0;
    @(negedge clk);
    checks++; if (rf_sel !== 5'd31) begin failures++; $display("FAIL xzr_rf_sel got=%0d exp=31", rf_sel); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL xzr_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL xzr_rsp_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL xzr_rsp_data got=%h exp=0", rsp_data); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) a[i] = 5'(i + 20);
    req_valid = 4'hF;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 4'd0) begin failures++; $display("FAIL midrst_req_ready got=%b exp=0000", req_ready); end
    tick();
    reset_n   = 1'b1;
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", rsp_valid); end
    checks++; if (rf_sel !== 5'd0) begin failures++; $display("FAIL midrst_rf_sel got=%0d exp=0", rf_sel); end
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_regrant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'd0;
  endtask

  task automatic test_random();
    bit         can;
    bit         ev;
    int         w;
    logic [3:0] eg;
    apply_reset();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        for (int i = 0; i < 4; i++) a[i] = 5'($urandom_range(0, 31));
        req_valid = 4'($urandom_range(0, 15));
        rsp_ready = ($urandom_range(0, 99) < 70);
      end else begin
        req_valid = 4'd0;
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      can = (m_cnt < 2) || rsp_ready;
      w   = can ? rr_winner(req_valid, m_ptr) : -1;
      eg  = (w >= 0) ? (4'd1 << w) : 4'd0;
      checks++; if (req_ready !== eg) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, req_ready, eg); end
      ev = (q_id.size() > 0) && (cyc >= q_acc[0] + 2);
      checks++; if (rsp_valid !== ev) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, ev); end
      if (ev && rsp_valid) begin
        checks++; if (rsp_id !== 2'(q_id[0])) begin failures++; $display("FAIL rnd_rsp_id cyc=%0d got=%0d exp=%0d", c, rsp_id, q_id[0]); end
        checks++; if (rsp_data !== q_data[0]) begin failures++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", c, rsp_data, q_data[0]); end
      end
      if (ev && rsp_ready) begin
        void'(q_id.pop_front());
        void'(q_data.pop_front());
        void'(q_acc.pop_front());
        m_cnt--;
      end
      if (w >= 0) begin
        q_id.push_back(w);
        q_data.push_back(rd_model(a[2'(w)]));
        q_acc.push_back(cyc);
        m_ptr = w;
        m_cnt++;
      end
      tick();
    end
    checks++; if (q_id.size() != 0) begin failures++; $display("FAIL rnd_lost_responses got=%0d exp=0", q_id.size()); end
  endtask

`ifdef RF_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    mem[7]    = 64'h1111;
    a[0]      = 5'd7;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL byp_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'd0;
    wr_en     = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 64'hABCD;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL byp_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 64'hABCD) begin failures++; $display("FAIL byp_rsp_data got=%h exp=abcd", rsp_data); end
    tick();
    a[0]      = 5'd31;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'd0;
    wr_en     = 1'b1;
    wr_addr   = 5'd31;
    wr_data   = 64'hABCD;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL byp_xzr_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL byp_xzr_data got=%h exp=0", rsp_data); end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) a[i] = 5'd0;
    for (int k = 0; k < 32; k++) mem[k[4:0]] = {$urandom, $urandom};
    mem[31] = '1;
`ifdef RF_BYPASS_EN
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 64'd0;
`endif
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_xzr();
    test_mid_reset();
    test_random();
`ifdef RF_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single 64-bit read port of the 32-entry register file among up to NREQ requesters (fetch/decode, forwarding check, debug). It arbitrates round-robin, drives the 5-bit select into the 32:1 read mux tree, captures the mux output and returns it with the requester ID over a valid/ready response channel. The block sits between the register file datapath and the pipeline front end, and is fully pipelined at one read per cycle.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 64: register data width
- IDW, $clog2(NREQ): response ID width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester read request
- req_addr  in  NREQ x 5  per-requester register number
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- rf_sel  out  5  to mux sel4..sel0; registered
- rf_rdata  in  WIDTH  combinational read mux output for rf_sel
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester served
- rsp_data  out  WIDTH  read data
- wr_en / wr_addr / wr_data  in  1 / 5 / WIDTH  write port snoop; present only with RF_BYPASS_EN

## Operation
- Two stages:
  - Stage A (sel): holds the accepted address and ID. rf_sel equals the A address.
  - Stage B (rsp): holds rsp_data and rsp_id. rsp_valid equals B valid.
- Stage B advances when B is empty or rsp_ready=1. Stage A advances when A is empty or B advances.
- Grant:
  - req_ready is nonzero only when A can advance this cycle.
  - The winner is the first valid requester, searching from rr_ptr+1 modulo NREQ. At most one bit of req_ready is set.
  - req_ready is a combinational function of req_valid, rr_ptr and stall. It never depends on rsp_data.
- rr_ptr updates to the winner index on each transfer only.
- Register 31 (XZR) is read as zero: when the A address is 31, B captures 0 regardless of rf_rdata.
- Holding: while A is valid and stalled, rf_sel must not change.
- Reset values: rf_sel=0, rr_ptr=NREQ-1 (requester 0 wins first), A/B valid=0, rsp_id=0, rsp_data=0, req_ready=0 while reset_n=0.
- Reset mid-operation: in-flight reads are discarded with no response. The requester re-issues.

## Timing
- A request accepted at edge N drives rf_sel during cycle N+1.
- rf_rdata is sampled at edge N+1. rsp_valid is high from cycle N+1 (after edge N+1) until accepted.
- Latency: accept to rsp_valid is 1 edge. Register data is sampled exactly one cycle after accept.
- Throughput: one response per cycle with rsp_ready held high.
- Backpressure: rsp_valid, rsp_id and rsp_data are stable until rsp_ready=1.
- A simultaneous rsp accept and new grant in the same cycle is allowed (no bubble).

## Configuration
- RF_BYPASS_EN defined:
  - Adds the wr_* ports.
  - When B captures, if wr_en=1, wr_addr equals the A address, and the address is not 31, B captures wr_data instead of rf_rdata. This covers a write landing the same cycle.
- RF_BYPASS_EN undefined:
  - The wr_* ports do not exist.
  - B always captures rf_rdata (or 0 for register 31).
  - Write-then-read ordering is the pipeline's responsibility.

## Structure
- Package regfile_pkg: NUM_REGS=32, REG_AW=5, ZERO_REG=5'd31, and a typedef rd_req_t {addr, id}.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs a one-hot grant and an encoded index. It is reusable for a later write-port arbiter.
- Stage registers and stall logic stay in the top-level module.

## Test plan
- Reset: hold reset_n=0 with all req_valid=1. Required: req_ready=0, rsp_valid=0, rf_sel=0. Release reset: requester 0 is granted first.
- Single read: req0 addr=5, rf_rdata model returns 64'h5555 for sel=5. Required: rf_sel=5 one cycle after accept, then rsp_valid=1, rsp_id=0, rsp_data=64'h5555.
- Round-robin: all 4 requesters valid continuously. Required: grants 0,1,2,3,0 on consecutive cycles, with responses back-to-back and no bubbles.
- Backpressure: drop rsp_ready for 3 cycles mid-stream. Required: rsp_* is stable, rf_sel is stable, req_ready=0 once A is full, and no response is lost or duplicated.
- XZR: read addr=31 while rf_rdata=all-ones. Required: rsp_data=0.
- Bypass (RF_BYPASS_EN): read addr=7 with wr_en=1, wr_addr=7, wr_data=64'hABCD in the capture cycle. Required: rsp_data=64'hABCD. With wr_addr=31: rsp_data=0.
